// File: rtl/ucsbece154_sdram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ucsbece154_sdram_responder
//  Purpose  : Behavioural SDRAM responder for a cache miss path. Accepts a
//             level read request, waits a fixed latency, then returns an
//             aligned block of words in ascending order. A backdoor load
//             port fills the backing store.
//  Revision : 1.0  initial release
// ============================================================================
module ucsbece154_sdram_responder #(
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 8,
    parameter int MEM_WORDS   = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] MemReadAddress,
    input  logic        MemReadRequest,
    output logic [31:0] MemDataIn,
    output logic        MemDataReady,
    output logic        Busy,
    input  logic        LoadEnable,
    input  logic [31:0] LoadAddress,
    input  logic [31:0] LoadData
);

    localparam int IDXW = $clog2(MEM_WORDS);
    localparam int BWL  = $clog2(BLOCK_WORDS);

    localparam logic [IDXW-1:0] c_BLK_MASK = IDXW'(BLOCK_WORDS - 1);
    localparam logic [BWL:0]    c_CNT_LAST = (BWL + 1)'(BLOCK_WORDS - 1);
    // Only reached when LATENCY >= 2; for LATENCY == 1 WAIT is skipped.
    localparam logic [7:0]      c_LAT_LAST = 8'(LATENCY - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        lat_q,   lat_d;
    logic [BWL:0]      cnt_q,   cnt_d;
    logic [IDXW-1:0]   base_q,  base_d;
    logic              ready_q, ready_d;
    logic [31:0]       data_q,  data_d;

    logic [31:0]       mem_q [MEM_WORDS];

    logic [IDXW-1:0]   w_req_idx;
    logic [IDXW-1:0]   w_load_idx;
    logic [IDXW-1:0]   w_rd_idx;

    // Word indices: upper address bits are dropped so addresses wrap.
    assign w_req_idx  = MemReadAddress[IDXW+1:2];
    assign w_load_idx = LoadAddress[IDXW+1:2];
    assign w_rd_idx   = base_q | IDXW'(cnt_q[BWL-1:0]);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{MemReadAddress[31:IDXW+2], MemReadAddress[1:0],
                                LoadAddress[31:IDXW+2], LoadAddress[1:0]};

    // Next-state and registered-output logic for the request/burst FSM.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        ready_d = 1'b0;
        data_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (MemReadRequest) begin
                    base_d  = w_req_idx & ~c_BLK_MASK;
                    lat_d   = '0;
                    cnt_d   = '0;
                    state_d = (LATENCY == 1) ? S_BURST : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!MemReadRequest) begin
                    state_d = S_IDLE;
                    lat_d   = '0;
                end else if (lat_q == c_LAT_LAST) begin
                    state_d = S_BURST;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            S_BURST: begin
                if (!MemReadRequest) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    // Read happens at the same edge as any load, so a
                    // colliding write is seen only by later bursts.
                    ready_d = 1'b1;
                    data_d  = mem_q[w_rd_idx];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == c_CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!MemReadRequest) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and output registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    // Backing store: backdoor writes in any state, untouched by reset.
    always_ff @(posedge Clk) begin
        if (LoadEnable) begin
            mem_q[w_load_idx] <= LoadData;
        end
    end

    assign MemDataReady = ready_q;
    assign MemDataIn    = data_q;
    assign Busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154_sdram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ucsbece154_sdram_responder
//  Purpose  : Directed self-checking bench for the SDRAM responder
//             (LATENCY=4 instance plus a LATENCY=1 instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ucsbece154_sdram_responder;

    logic        Clk;
    logic        Reset;
    logic [31:0] MemReadAddress;
    logic        MemReadRequest;
    logic [31:0] MemDataIn;
    logic        MemDataReady;
    logic        Busy;
    logic        LoadEnable;
    logic [31:0] LoadAddress;
    logic [31:0] LoadData;

    logic [31:0] addr1;
    logic        req1;
    logic [31:0] dat1;
    logic        rdy1;
    logic        busy1;

    int n_cmp = 0;
    int n_err = 0;

    ucsbece154_sdram_responder #(
        .BLOCK_WORDS(4), .LATENCY(4), .MEM_WORDS(1024)
    ) u_dut (
        .Clk(Clk), .Reset(Reset),
        .MemReadAddress(MemReadAddress), .MemReadRequest(MemReadRequest),
        .MemDataIn(MemDataIn), .MemDataReady(MemDataReady), .Busy(Busy),
        .LoadEnable(LoadEnable), .LoadAddress(LoadAddress), .LoadData(LoadData)
    );

    ucsbece154_sdram_responder #(
        .BLOCK_WORDS(4), .LATENCY(1), .MEM_WORDS(1024)
    ) u_dut1 (
        .Clk(Clk), .Reset(Reset),
        .MemReadAddress(addr1), .MemReadRequest(req1),
        .MemDataIn(dat1), .MemDataReady(rdy1), .Busy(busy1),
        .LoadEnable(LoadEnable), .LoadAddress(LoadAddress), .LoadData(LoadData)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] pat(input int idx);
        return 32'hA500_0000 + 32'(idx);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] d);
        LoadEnable  = 1'b1;
        LoadAddress = 32'(idx) << 2;
        LoadData    = d;
        tick();
        LoadEnable  = 1'b0;
    endtask

    // Raise request, take the accepting edge, check Busy right after it.
    task automatic accept(input string tag, input logic [31:0] addr);
        MemReadAddress = addr;
        MemReadRequest = 1'b1;
        tick();
        check({tag, "_busy"}, 32'(Busy), 32'd1);
        check({tag, "_rdy0"}, 32'(MemDataReady), 32'd0);
    endtask

    task automatic wait_lat(input string tag);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check({tag, "_wait_rdy"}, 32'(MemDataReady), 32'd0);
            check({tag, "_wait_dat"}, MemDataIn, 32'd0);
        end
    endtask

    task automatic burst_word(input string tag, input logic [31:0] exp);
        tick();
        check({tag, "_rdy"}, 32'(MemDataReady), 32'd1);
        check({tag, "_dat"}, MemDataIn, exp);
    endtask

    initial begin
        Reset          = 1'b0;
        MemReadAddress = '0;
        MemReadRequest = 1'b0;
        LoadEnable     = 1'b0;
        LoadAddress    = '0;
        LoadData       = '0;
        addr1          = '0;
        req1           = 1'b0;
        #1;
        check("reset_rdy",  32'(MemDataReady), 32'd0);
        check("reset_dat",  MemDataIn,         32'd0);
        check("reset_busy", 32'(Busy),         32'd0);
        tick();
        tick();
        Reset = 1'b1;

        for (int i = 0; i < 16; i++) load_word(i, pat(i));
        for (int i = 1020; i < 1024; i++) load_word(i, pat(i));

        // Basic burst: 0x18 -> block base word 4; address change after accept ignored.
        accept("basic", 32'h18);
        MemReadAddress = 32'h40;
        wait_lat("basic");
        for (int k = 0; k < 4; k++) burst_word($sformatf("basic_w%0d", k), pat(4 + k));
        // Hold-off: request stays high, no second burst.
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_rdy",  32'(MemDataReady), 32'd0);
            check("hold_busy", 32'(Busy),         32'd1);
        end
        MemReadRequest = 1'b0;
        tick();
        check("hold_idle", 32'(Busy), 32'd0);
        accept("second", 32'h20);
        wait_lat("second");
        for (int k = 0; k < 4; k++) burst_word($sformatf("second_w%0d", k), pat(8 + k));
        MemReadRequest = 1'b0;
        tick();
        check("second_idle", 32'(Busy), 32'd0);

        // Abort after the first word.
        accept("abort", 32'h18);
        wait_lat("abort");
        burst_word("abort_w0", pat(4));
        MemReadRequest = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_rdy",  32'(MemDataReady), 32'd0);
            check("abort_dat",  MemDataIn,         32'd0);
            check("abort_busy", 32'(Busy),         32'd0);
        end

        // Wrap and read-before-write collision on word 1021.
        accept("wrap", 32'h1000_0FF4);
        wait_lat("wrap");
        burst_word("wrap_w0", pat(1020));
        LoadEnable  = 1'b1;
        LoadAddress = 32'h0000_0FF4;
        LoadData    = 32'h0000_DEAD;
        burst_word("wrap_w1_old", pat(1021));
        LoadEnable  = 1'b0;
        burst_word("wrap_w2", pat(1022));
        burst_word("wrap_w3", pat(1023));
        MemReadRequest = 1'b0;
        tick();
        accept("wrap2", 32'h0000_0FF0);
        wait_lat("wrap2");
        burst_word("wrap2_w0", pat(1020));
        burst_word("wrap2_w1_new", 32'h0000_DEAD);
        MemReadRequest = 1'b0;
        tick();

        // Reset mid-WAIT: outputs drop without a clock edge.
        accept("rstw", 32'h18);
        tick();
        #2 Reset = 1'b0;
        #1;
        check("rstw_rdy",  32'(MemDataReady), 32'd0);
        check("rstw_busy", 32'(Busy),         32'd0);
        MemReadRequest = 1'b0;
        tick();
        Reset = 1'b1;
        // Reset mid-BURST while a word is on the bus.
        accept("rstb", 32'h18);
        wait_lat("rstb");
        burst_word("rstb_w0", pat(4));
        #2 Reset = 1'b0;
        #1;
        check("rstb_rdy",  32'(MemDataReady), 32'd0);
        check("rstb_dat",  MemDataIn,         32'd0);
        check("rstb_busy", 32'(Busy),         32'd0);
        MemReadRequest = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        // Fresh request after reset: memory unchanged.
        accept("post", 32'h1C);
        wait_lat("post");
        for (int k = 0; k < 4; k++) burst_word($sformatf("post_w%0d", k), pat(4 + k));
        MemReadRequest = 1'b0;
        tick();

        // LATENCY=1 instance: first word one edge after acceptance.
        addr1 = 32'h08;
        req1  = 1'b1;
        tick();
        check("lat1_busy", 32'(busy1), 32'd1);
        check("lat1_rdy0", 32'(rdy1),  32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("lat1_rdy%0d", k), 32'(rdy1), 32'd1);
            check($sformatf("lat1_dat%0d", k), dat1, pat(k));
        end
        tick();
        check("lat1_done_rdy", 32'(rdy1), 32'd0);
        check("lat1_done_dat", dat1,      32'd0);
        req1 = 1'b0;
        tick();
        check("lat1_idle", 32'(busy1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
